// File: rtl/scroll_vram_arbiter_pkg.sv
// Shared constants for the scroll tilemap VRAM arbiter: slot phases,
// fetch tag encodings, CPU port FSM encodings and the CPU slot decode.
// Macro SCROLL_ARB_LAYER_B_EN enables the layer B fetch slots (phases 2-3);
// without it those phases are handed to the CPU.
package scroll_vram_arbiter_pkg;

  localparam logic [2:0] SLOT_A_NAME = 3'd0;
  localparam logic [2:0] SLOT_A_ATTR = 3'd1;
  localparam logic [2:0] SLOT_B_NAME = 3'd2;
  localparam logic [2:0] SLOT_B_ATTR = 3'd3;

`ifdef SCROLL_ARB_LAYER_B_EN
  localparam logic [2:0] SLOT_CPU_FIRST = 3'd4;
`else
  localparam logic [2:0] SLOT_CPU_FIRST = 3'd2;
`endif

  // Tag carried alongside each issued RAM address until its data returns
  localparam logic [2:0] TAG_NONE   = 3'd0;
  localparam logic [2:0] TAG_A_NAME = 3'd1;
  localparam logic [2:0] TAG_A_ATTR = 3'd2;
  localparam logic [2:0] TAG_B_NAME = 3'd3;
  localparam logic [2:0] TAG_B_ATTR = 3'd4;
  localparam logic [2:0] TAG_CPU_RD = 3'd5;

  localparam logic [1:0] CPU_IDLE  = 2'd0;
  localparam logic [1:0] CPU_PEND  = 2'd1;
  localparam logic [1:0] CPU_GRANT = 2'd2;
  localparam logic [1:0] CPU_DONE  = 2'd3;

  function automatic logic is_cpu_slot(input logic [2:0] ph);
    return ph >= SLOT_CPU_FIRST;
  endfunction

endpackage

// File: rtl/scroll_cpu_port.sv
// CPU side of the tilemap arbiter: request FSM, read data register and the
// wait signal. The parent supplies the CPU slot decode and the read-capture
// strobe from its tag pipeline; this block tells the parent when to issue.
//
//   state | meaning
//   IDLE  | no request, or previous access released
//   PEND  | cpu_cs_n low, waiting for a CPU slot
//   GRANT | access issued to RAM, waiting for write slot / read data
//   DONE  | access complete, CPU released until cpu_cs_n goes high
module scroll_cpu_port
  import scroll_vram_arbiter_pkg::*;
(
  input  logic       CLK_6M,
  input  logic       rst,
  input  logic       cpu_cs_n,
  input  logic       cpu_rw,
  input  logic       cpu_slot,
  input  logic       rd_capture,
  input  logic [7:0] rd_data,
  output logic       cpu_issue,
  output logic [7:0] cpu_dout,
  output logic       cpu_mrdy_n
);

  logic [1:0] state_q, state_d;
  logic       wr_q, wr_d;
  logic       done_q, done_d;
  logic [7:0] dout_q, dout_d;

  // Issue at the first CPU slot edge of an unserved request
  assign cpu_issue = ~cpu_cs_n & cpu_slot & ((state_q == CPU_IDLE) | (state_q == CPU_PEND));

  // Next-state logic; a released select aborts PEND/GRANT without touching cpu_dout
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    if (cpu_issue) wr_d = ~cpu_rw;
    case (state_q)
      CPU_IDLE: begin
        if (!cpu_cs_n) state_d = cpu_slot ? CPU_GRANT : CPU_PEND;
      end
      CPU_PEND: begin
        if (cpu_cs_n)      state_d = CPU_IDLE;
        else if (cpu_slot) state_d = CPU_GRANT;
      end
      CPU_GRANT: begin
        if (cpu_cs_n) begin
          state_d = CPU_IDLE;
        end else if (wr_q) begin
          state_d = CPU_DONE;
        end else if (rd_capture) begin
          dout_d  = rd_data;
          state_d = CPU_DONE;
        end
      end
      CPU_DONE: begin
        if (cpu_cs_n) state_d = CPU_IDLE;
      end
      default: state_d = CPU_IDLE;
    endcase
    done_d = (state_d == CPU_DONE);
  end

  // FSM and data registers
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      state_q <= CPU_IDLE;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  assign cpu_dout   = dout_q;
  assign cpu_mrdy_n = cpu_cs_n | done_q;

endmodule

// File: rtl/scroll_vram_arbiter.sv
// Time-slot arbiter for the scroll tilemap VRAM. hphase selects the slot
// owner each pixel clock; layer fetches return through a 2-stage tag
// pipeline and are paired into {attr, name} tile codes.
// Macro SCROLL_ARB_LAYER_B_EN enables the layer B fetch (phases 2-3).
module scroll_vram_arbiter
  import scroll_vram_arbiter_pkg::*;
(
  input  logic        CLK_6M,
  input  logic        rst,
  input  logic [2:0]  hphase,
  input  logic [11:0] layer_a_tile,
  input  logic [11:0] layer_b_tile,
  input  logic        cpu_cs_n,
  input  logic        cpu_rw,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_mrdy_n,
  output logic [12:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_din,
  input  logic [7:0]  vram_dout,
  output logic [15:0] tile_a_code,
  output logic [15:0] tile_b_code,
  output logic        tile_a_stb,
  output logic        tile_b_stb
);

  logic        cpu_slot;
  logic        cpu_issue;
  logic        rd_capture;
  logic [2:0]  tag1_q, tag2_q;
  logic [12:0] vram_addr_q;
  logic        vram_we_q;
  logic [7:0]  vram_din_q;

  assign cpu_slot   = is_cpu_slot(hphase);
  assign rd_capture = (tag2_q == TAG_CPU_RD);

  scroll_cpu_port u_cpu_port (
    .CLK_6M     (CLK_6M),
    .rst        (rst),
    .cpu_cs_n   (cpu_cs_n),
    .cpu_rw     (cpu_rw),
    .cpu_slot   (cpu_slot),
    .rd_capture (rd_capture),
    .rd_data    (vram_dout),
    .cpu_issue  (cpu_issue),
    .cpu_dout   (cpu_dout),
    .cpu_mrdy_n (cpu_mrdy_n)
  );

  // Register the slot owner's RAM request and advance the tag pipeline
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      vram_addr_q <= 13'h0000;
      vram_we_q   <= 1'b0;
      vram_din_q  <= 8'h00;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
    end else begin
      vram_we_q <= 1'b0;
      tag1_q    <= TAG_NONE;
      tag2_q    <= tag1_q;
      if (hphase == SLOT_A_NAME) begin
        vram_addr_q <= {layer_a_tile, 1'b0};
        tag1_q      <= TAG_A_NAME;
      end else if (hphase == SLOT_A_ATTR) begin
        vram_addr_q <= {layer_a_tile, 1'b1};
        tag1_q      <= TAG_A_ATTR;
      end
`ifdef SCROLL_ARB_LAYER_B_EN
      else if (hphase == SLOT_B_NAME) begin
        vram_addr_q <= {layer_b_tile, 1'b0};
        tag1_q      <= TAG_B_NAME;
      end else if (hphase == SLOT_B_ATTR) begin
        vram_addr_q <= {layer_b_tile, 1'b1};
        tag1_q      <= TAG_B_ATTR;
      end
`endif
      else if (cpu_issue) begin
        vram_addr_q <= cpu_addr;
        vram_we_q   <= ~cpu_rw;
        vram_din_q  <= cpu_din;
        tag1_q      <= cpu_rw ? TAG_CPU_RD : TAG_NONE;
      end
    end
  end

  assign vram_addr = vram_addr_q;
  assign vram_we   = vram_we_q;
  assign vram_din  = vram_din_q;

  logic [7:0]  a_name_q;
  logic        a_name_ok_q;
  logic [15:0] a_code_q;
  logic        a_stb_q;

  // Layer A: only a name captured on the edge just before the attr forms a code
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      a_name_q    <= 8'h00;
      a_name_ok_q <= 1'b0;
      a_code_q    <= 16'h0000;
      a_stb_q     <= 1'b0;
    end else begin
      a_stb_q     <= 1'b0;
      a_name_ok_q <= (tag2_q == TAG_A_NAME);
      if (tag2_q == TAG_A_NAME) a_name_q <= vram_dout;
      if ((tag2_q == TAG_A_ATTR) && a_name_ok_q) begin
        a_code_q <= {vram_dout, a_name_q};
        a_stb_q  <= 1'b1;
      end
    end
  end

  assign tile_a_code = a_code_q;
  assign tile_a_stb  = a_stb_q;

`ifdef SCROLL_ARB_LAYER_B_EN
  logic [7:0]  b_name_q;
  logic        b_name_ok_q;
  logic [15:0] b_code_q;
  logic        b_stb_q;

  // Layer B: same pairing rule as layer A
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      b_name_q    <= 8'h00;
      b_name_ok_q <= 1'b0;
      b_code_q    <= 16'h0000;
      b_stb_q     <= 1'b0;
    end else begin
      b_stb_q     <= 1'b0;
      b_name_ok_q <= (tag2_q == TAG_B_NAME);
      if (tag2_q == TAG_B_NAME) b_name_q <= vram_dout;
      if ((tag2_q == TAG_B_ATTR) && b_name_ok_q) begin
        b_code_q <= {vram_dout, b_name_q};
        b_stb_q  <= 1'b1;
      end
    end
  end

  assign tile_b_code = b_code_q;
  assign tile_b_stb  = b_stb_q;
`else
  logic unused_layer_b;
  assign unused_layer_b = ^layer_b_tile;
  assign tile_b_code    = 16'h0000;
  assign tile_b_stb     = 1'b0;
`endif

endmodule
